stg_ma: RTL and testbench
=========================

Name: stg_ma

Overview:
Memory-access pipeline stage. It sits directly downstream of the execute stage and upstream of write-back. It consumes the execute stage's latched address, result and target fields, and issues word-wide loads and stores to the data memory over a req/ack handshake with variable latency. It stalls upstream stages while an access is outstanding and forwards a registered result and target info to write-back.

Parameters:
- TIMEOUT_CYC, 16: WAIT cycles before abort. Only used with STG_MA_TIMEOUT_EN.

Ports:
- iw_clk  in  1  clock
- iw_rst  in  1  reset
- iw_pc  in  `SIZE_ADDR  pc from execute
- ow_pc  out  `SIZE_ADDR  registered pc
- iw_instr  in  `SIZE_DATA  instruction word
- ow_instr  out  `SIZE_DATA  registered instruction word
- iw_opc  in  `SIZE_OPC  opcode
- ow_opc  out  `SIZE_OPC  registered opcode
- iw_tgt_gp / iw_tgt_gp_we  in  `SIZE_TGT_GP / 1  gp target and write enable
- ow_tgt_gp / ow_tgt_gp_we  out  `SIZE_TGT_GP / 1  registered gp target and write enable
- iw_tgt_sr / iw_tgt_sr_we  in  `SIZE_TGT_SR / 1  sr target and write enable
- ow_tgt_sr / ow_tgt_sr_we  out  `SIZE_TGT_SR / 1  registered sr target and write enable
- iw_addr  in  `SIZE_ADDR  effective address
- iw_result  in  `SIZE_DATA  ALU result, or store data
- ow_result  out  `SIZE_DATA  write-back value
- ow_stall  out  1  freeze fetch/decode/execute registers (combinational)
- or_mem_req  out  1  memory request
- or_mem_we  out  1  1 = store
- or_mem_addr  out  `SIZE_ADDR  memory address
- or_mem_wdata  out  `SIZE_DATA  store data
- iw_mem_ack  in  1  access complete; rdata valid on a load
- iw_mem_rdata  in  `SIZE_DATA  load data
- or_mem_fault  out  1  timeout pulse (feature only, else tied 0)

Behaviour:
- Reset is asynchronous, active-high on iw_rst; clock is iw_clk. Every output register resets to 0, and the FSM resets to IDLE.
- Memory op decode from iw_opc:
  - load = `OPC_RU_LDu
  - store = `OPC_RU_STu, `OPC_IU_STiu, `OPC_IS_STis
  - mem_op = load | store
- FSM has two states, IDLE and WAIT.
  - IDLE, mem_op=0: pipeline register captures all iw_* fields; ow_result = iw_result; latency 1 cycle. or_mem_req stays 0.
  - IDLE, mem_op=1: next edge goes to WAIT and loads or_mem_req=1, or_mem_we=store, or_mem_addr=iw_addr, or_mem_wdata=iw_result. The output register takes a bubble: ow_tgt_gp_we=0, ow_tgt_sr_we=0, ow_opc=0, other fields hold.
  - WAIT, ack=0: req/we/addr/wdata hold stable; bubble continues.
  - WAIT, ack=1: next edge goes to IDLE with req=0 and we=0. The output register captures all iw_* fields. ow_result = iw_mem_rdata for a load, iw_result for a store.
- ow_stall = mem_op & ~(state==WAIT & iw_mem_ack).
  - Upstream holds its registers while ow_stall=1, so iw_* fields are stable throughout an access.
  - Stall drops in the ack cycle, so execute advances on the same edge that retires the access.
  - No re-issue of the same instruction.
- iw_mem_ack is ignored in IDLE. The memory side must not ack before req.
- Ack in the first WAIT cycle is allowed. The minimum memory-op latency is 2 cycles (issue edge plus ack edge).
- Back-to-back memory ops: the next request issues the edge after the previous ack, giving exactly one req-low cycle between requests.
- Reset mid-access: req drops asynchronously, the FSM returns to IDLE, the access is abandoned, and nothing is written back.
- Access is word-addressed and full-width; there are no byte lanes or alignment checks.

Optional Feature:
- Macro: STG_MA_TIMEOUT_EN.
- When defined:
  - A 16-bit counter clears on WAIT entry and increments on each WAIT cycle without ack.
  - When the count reaches TIMEOUT_CYC-1 with no ack, the next edge goes to IDLE with req=0. The output register captures iw_* with ow_tgt_gp_we=0, ow_tgt_sr_we=0 and ow_result=0. or_mem_fault pulses 1 for that one registered cycle.
  - ow_stall also drops in that last cycle.
  - Ack and timeout in the same cycle: ack wins.
- When undefined: no counter, WAIT waits indefinitely, or_mem_fault is constant 0.

Test Plan:
1. ADDu result 0x000123, tgt_gp=3, we=1 → next edge ow_result=0x000123, ow_tgt_gp=3, ow_tgt_gp_we=1; or_mem_req never 1; ow_stall=0.
2. LDu addr 0x000040, tgt_gp=5; ack with rdata 0xABCDEF in the 3rd WAIT cycle → req=1, we=0, addr=0x000040 for 3 cycles; ow_stall=1 for 3 cycles then 0; bubbles have ow_tgt_gp_we=0; after the ack edge ow_result=0xABCDEF, ow_tgt_gp=5, we=1.
3. STiu addr 0x000010, data 0x00BEEF; ack in the first WAIT cycle → one req cycle with we=1, addr=0x000010, wdata=0x00BEEF; ow_result=0x00BEEF; ow_stall high for 1 cycle.
4. LDu then LDu, each acked on the first WAIT cycle → req pattern 1,0,1; the second request carries the second address; both results are written back in order.
5. iw_rst asserted during the 2nd WAIT cycle of a load → or_mem_req=0 immediately; all outputs 0; after release, FSM is in IDLE and the held instruction re-issues.
6. With STG_MA_TIMEOUT_EN, TIMEOUT_CYC=4, never ack → req high 4 cycles, then or_mem_fault=1 for one cycle, ow_tgt_gp_we=0, ow_result=0, ow_stall=0 in the 4th WAIT cycle.

Source files
------------

// File: rtl/stg_ma.sv
// stg_ma: memory-access pipeline stage issuing word loads/stores over a req/ack handshake
//   iw_clk, iw_rst         clock, asynchronous active-high reset
//   iw_pc/instr/opc/tgt_*  execute-stage fields, forwarded registered on ow_*
//   iw_addr, iw_result     effective address and ALU result / store data
//   ow_result              write-back value (load data or ALU result)
//   ow_stall               combinational freeze of fetch/decode/execute
//   or_mem_*, iw_mem_*     data-memory request/ack interface
//   or_mem_fault           timeout pulse, only with STG_MA_TIMEOUT_EN defined
`ifndef SIZE_ADDR
`define SIZE_ADDR 24
`endif
`ifndef SIZE_DATA
`define SIZE_DATA 24
`endif
`ifndef SIZE_OPC
`define SIZE_OPC 6
`endif
`ifndef SIZE_TGT_GP
`define SIZE_TGT_GP 4
`endif
`ifndef SIZE_TGT_SR
`define SIZE_TGT_SR 2
`endif
`ifndef OPC_RU_LDu
`define OPC_RU_LDu 6'h10
`endif
`ifndef OPC_RU_STu
`define OPC_RU_STu 6'h11
`endif
`ifndef OPC_IU_STiu
`define OPC_IU_STiu 6'h12
`endif
`ifndef OPC_IS_STis
`define OPC_IS_STis 6'h13
`endif

module stg_ma #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                    iw_clk,
  input  logic                    iw_rst,
  input  logic [`SIZE_ADDR-1:0]   iw_pc,
  output logic [`SIZE_ADDR-1:0]   ow_pc,
  input  logic [`SIZE_DATA-1:0]   iw_instr,
  output logic [`SIZE_DATA-1:0]   ow_instr,
  input  logic [`SIZE_OPC-1:0]    iw_opc,
  output logic [`SIZE_OPC-1:0]    ow_opc,
  input  logic [`SIZE_TGT_GP-1:0] iw_tgt_gp,
  input  logic                    iw_tgt_gp_we,
  output logic [`SIZE_TGT_GP-1:0] ow_tgt_gp,
  output logic                    ow_tgt_gp_we,
  input  logic [`SIZE_TGT_SR-1:0] iw_tgt_sr,
  input  logic                    iw_tgt_sr_we,
  output logic [`SIZE_TGT_SR-1:0] ow_tgt_sr,
  output logic                    ow_tgt_sr_we,
  input  logic [`SIZE_ADDR-1:0]   iw_addr,
  input  logic [`SIZE_DATA-1:0]   iw_result,
  output logic [`SIZE_DATA-1:0]   ow_result,
  output logic                    ow_stall,
  output logic                    or_mem_req,
  output logic                    or_mem_we,
  output logic [`SIZE_ADDR-1:0]   or_mem_addr,
  output logic [`SIZE_DATA-1:0]   or_mem_wdata,
  input  logic                    iw_mem_ack,
  input  logic [`SIZE_DATA-1:0]   iw_mem_rdata,
  output logic                    or_mem_fault
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state_q, state_d;
  logic [`SIZE_ADDR-1:0] pc_q, pc_d, addr_q, addr_d;
  logic [`SIZE_DATA-1:0] instr_q, instr_d, result_q, result_d, wdata_q, wdata_d;
  logic [`SIZE_OPC-1:0] opc_q, opc_d;
  logic [`SIZE_TGT_GP-1:0] gp_q, gp_d;
  logic [`SIZE_TGT_SR-1:0] sr_q, sr_d;
  logic gp_we_q, gp_we_d, sr_we_q, sr_we_d, req_q, req_d, we_q, we_d;
  logic load, store, mem_op, ack, to;
  assign load = iw_opc == `OPC_RU_LDu;
  assign store = iw_opc == `OPC_RU_STu || iw_opc == `OPC_IU_STiu || iw_opc == `OPC_IS_STis;
  assign mem_op = load | store;
  assign ack = state_q == WAIT && iw_mem_ack;
  assign ow_stall = mem_op & ~(ack | to);
`ifdef STG_MA_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic fault_q;
  assign to = state_q == WAIT && !iw_mem_ack && cnt_q == 16'(TIMEOUT_CYC - 1);
  // Held at zero while idle, so it is already clear on WAIT entry.
  assign cnt_d = state_q == IDLE ? 16'd0 : cnt_q + 16'd1;
  assign or_mem_fault = fault_q;
  always_ff @(posedge iw_clk or posedge iw_rst)
    if (iw_rst) begin
      cnt_q <= '0;
      fault_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      fault_q <= to;
    end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
  assign to = 1'b0;
  assign or_mem_fault = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    instr_d = instr_q;
    opc_d = opc_q;
    gp_d = gp_q;
    gp_we_d = gp_we_q;
    sr_d = sr_q;
    sr_we_d = sr_we_q;
    result_d = result_q;
    req_d = req_q;
    we_d = we_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    if (state_q == IDLE && mem_op) begin
      state_d = WAIT;
      req_d = 1'b1;
      we_d = store;
      addr_d = iw_addr;
      wdata_d = iw_result;
      opc_d = '0;
      gp_we_d = 1'b0;
      sr_we_d = 1'b0;
    end else if (state_q == IDLE || ack || to) begin
      state_d = IDLE;
      req_d = 1'b0;
      we_d = 1'b0;
      pc_d = iw_pc;
      instr_d = iw_instr;
      opc_d = iw_opc;
      gp_d = iw_tgt_gp;
      sr_d = iw_tgt_sr;
      gp_we_d = iw_tgt_gp_we & ~to;
      sr_we_d = iw_tgt_sr_we & ~to;
      result_d = to ? '0 : ack && load ? iw_mem_rdata : iw_result;
    end
  end
  always_ff @(posedge iw_clk or posedge iw_rst)
    if (iw_rst) begin
      state_q <= IDLE;
      pc_q <= '0;
      instr_q <= '0;
      opc_q <= '0;
      gp_q <= '0;
      gp_we_q <= 1'b0;
      sr_q <= '0;
      sr_we_q <= 1'b0;
      result_q <= '0;
      req_q <= 1'b0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      instr_q <= instr_d;
      opc_q <= opc_d;
      gp_q <= gp_d;
      gp_we_q <= gp_we_d;
      sr_q <= sr_d;
      sr_we_q <= sr_we_d;
      result_q <= result_d;
      req_q <= req_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
    end
  assign ow_pc = pc_q;
  assign ow_instr = instr_q;
  assign ow_opc = opc_q;
  assign ow_tgt_gp = gp_q;
  assign ow_tgt_gp_we = gp_we_q;
  assign ow_tgt_sr = sr_q;
  assign ow_tgt_sr_we = sr_we_q;
  assign ow_result = result_q;
  assign or_mem_req = req_q;
  assign or_mem_we = we_q;
  assign or_mem_addr = addr_q;
  assign or_mem_wdata = wdata_q;
endmodule

// File: tb/tb_stg_ma.sv
// tb_stg_ma: directed self-checking bench for stg_ma
`ifndef SIZE_ADDR
`define SIZE_ADDR 24
`endif
`ifndef SIZE_DATA
`define SIZE_DATA 24
`endif
`ifndef SIZE_OPC
`define SIZE_OPC 6
`endif
`ifndef SIZE_TGT_GP
`define SIZE_TGT_GP 4
`endif
`ifndef SIZE_TGT_SR
`define SIZE_TGT_SR 2
`endif
`ifndef OPC_RU_LDu
`define OPC_RU_LDu 6'h10
`endif
`ifndef OPC_RU_STu
`define OPC_RU_STu 6'h11
`endif
`ifndef OPC_IU_STiu
`define OPC_IU_STiu 6'h12
`endif
`ifndef OPC_IS_STis
`define OPC_IS_STis 6'h13
`endif

module tb_stg_ma;
  localparam logic [`SIZE_OPC-1:0] OPC_ADD = `SIZE_OPC'(1);
  logic clk = 1'b0, rst = 1'b1;
  logic [`SIZE_ADDR-1:0] pc = '0, addr = '0, o_pc, m_addr;
  logic [`SIZE_DATA-1:0] instr = '0, result = '0, rdata = '0, o_instr, o_result, m_wdata;
  logic [`SIZE_OPC-1:0] opc = '0, o_opc;
  logic [`SIZE_TGT_GP-1:0] gp = '0, o_gp;
  logic [`SIZE_TGT_SR-1:0] sr = '0, o_sr;
  logic gp_we = 1'b0, sr_we = 1'b0, ack = 1'b0;
  logic o_gp_we, o_sr_we, stall, m_req, m_we, m_fault;
  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  stg_ma #(.TIMEOUT_CYC(4)) dut (
    .iw_clk(clk), .iw_rst(rst),
    .iw_pc(pc), .ow_pc(o_pc), .iw_instr(instr), .ow_instr(o_instr),
    .iw_opc(opc), .ow_opc(o_opc),
    .iw_tgt_gp(gp), .iw_tgt_gp_we(gp_we), .ow_tgt_gp(o_gp), .ow_tgt_gp_we(o_gp_we),
    .iw_tgt_sr(sr), .iw_tgt_sr_we(sr_we), .ow_tgt_sr(o_sr), .ow_tgt_sr_we(o_sr_we),
    .iw_addr(addr), .iw_result(result), .ow_result(o_result), .ow_stall(stall),
    .or_mem_req(m_req), .or_mem_we(m_we), .or_mem_addr(m_addr), .or_mem_wdata(m_wdata),
    .iw_mem_ack(ack), .iw_mem_rdata(rdata), .or_mem_fault(m_fault)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [`SIZE_OPC-1:0] o, input logic [`SIZE_ADDR-1:0] a,
                        input logic [`SIZE_DATA-1:0] r, input logic [`SIZE_TGT_GP-1:0] g,
                        input logic gwe);
    opc = o; addr = a; result = r; gp = g; gp_we = gwe;
    pc = pc + 24'd1; instr = {opc, 18'h0} | 24'h000abc;
    sr = 2'd1; sr_we = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) tick;
    n_tests++;
    if ({o_pc, o_instr, o_opc, o_gp, o_gp_we, o_sr, o_sr_we, o_result} !== '0) begin
      n_fail++; $display("FAIL reset_outs got=%h want=0", {o_pc, o_instr, o_opc, o_gp, o_result}); end
    n_tests++;
    if ({m_req, m_we, m_addr, m_wdata, m_fault, stall} !== '0) begin
      n_fail++; $display("FAIL reset_mem got req=%b we=%b addr=%h stall=%b want 0", m_req, m_we, m_addr, stall); end
    rst = 1'b0;
  endtask

  task automatic test_alu;
    set_op(OPC_ADD, 24'h000999, 24'h000123, 4'd3, 1'b1);
    n_tests++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL alu_stall got=%b want=0", stall); end
    tick;
    n_tests++;
    if (o_result !== 24'h000123 || o_gp !== 4'd3 || o_gp_we !== 1'b1 || o_opc !== OPC_ADD || o_pc !== pc) begin
      n_fail++; $display("FAIL alu_wb got res=%h gp=%0d we=%b opc=%h want 000123/3/1/%h", o_result, o_gp, o_gp_we, o_opc, OPC_ADD); end
    n_tests++;
    if (m_req !== 1'b0) begin n_fail++; $display("FAIL alu_req got=%b want=0", m_req); end
  endtask

  task automatic test_load;
    set_op(`OPC_RU_LDu, 24'h000040, 24'h000777, 4'd5, 1'b1);
    n_tests++;
    if (stall !== 1'b1) begin n_fail++; $display("FAIL ld_stall0 got=%b want=1", stall); end
    for (int i = 0; i < 3; i++) begin
      tick;
      n_tests++;
      if (m_req !== 1'b1 || m_we !== 1'b0 || m_addr !== 24'h000040) begin
        n_fail++; $display("FAIL ld_req%0d got req=%b we=%b addr=%h want 1/0/000040", i, m_req, m_we, m_addr); end
      n_tests++;
      if (o_gp_we !== 1'b0 || o_opc !== '0) begin
        n_fail++; $display("FAIL ld_bubble%0d got we=%b opc=%h want 0/0", i, o_gp_we, o_opc); end
      if (i == 2) begin ack = 1'b1; rdata = 24'hABCDEF; #1; end
      n_tests++;
      if (stall !== (i != 2)) begin n_fail++; $display("FAIL ld_stall%0d got=%b want=%b", i, stall, i != 2); end
    end
    tick;
    ack = 1'b0;
    n_tests++;
    if (o_result !== 24'hABCDEF || o_gp !== 4'd5 || o_gp_we !== 1'b1 || m_req !== 1'b0) begin
      n_fail++; $display("FAIL ld_wb got res=%h gp=%0d we=%b req=%b want abcdef/5/1/0", o_result, o_gp, o_gp_we, m_req); end
    set_op(OPC_ADD, '0, '0, '0, 1'b0);
  endtask

  task automatic test_store;
    set_op(`OPC_IU_STiu, 24'h000010, 24'h00BEEF, 4'd2, 1'b0);
    n_tests++;
    if (stall !== 1'b1) begin n_fail++; $display("FAIL st_stall0 got=%b want=1", stall); end
    tick;
    n_tests++;
    if (m_req !== 1'b1 || m_we !== 1'b1 || m_addr !== 24'h000010 || m_wdata !== 24'h00BEEF) begin
      n_fail++; $display("FAIL st_req got req=%b we=%b addr=%h wd=%h want 1/1/000010/00beef", m_req, m_we, m_addr, m_wdata); end
    ack = 1'b1; #1;
    n_tests++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL st_stall1 got=%b want=0", stall); end
    tick;
    ack = 1'b0;
    n_tests++;
    if (m_req !== 1'b0 || m_we !== 1'b0 || o_result !== 24'h00BEEF || o_opc !== `OPC_IU_STiu) begin
      n_fail++; $display("FAIL st_wb got req=%b we=%b res=%h opc=%h want 0/0/00beef/12", m_req, m_we, o_result, o_opc); end
    set_op(OPC_ADD, '0, '0, '0, 1'b0);
  endtask

  task automatic test_back_to_back;
    set_op(`OPC_RU_LDu, 24'h000100, '0, 4'd1, 1'b1);
    tick;
    n_tests++;
    if (m_req !== 1'b1 || m_addr !== 24'h000100) begin
      n_fail++; $display("FAIL b2b_req1 got req=%b addr=%h want 1/000100", m_req, m_addr); end
    ack = 1'b1; rdata = 24'h000111;
    tick;
    ack = 1'b0;
    n_tests++;
    if (m_req !== 1'b0 || o_result !== 24'h000111 || o_gp !== 4'd1 || o_gp_we !== 1'b1) begin
      n_fail++; $display("FAIL b2b_wb1 got req=%b res=%h gp=%0d want 0/000111/1", m_req, o_result, o_gp); end
    set_op(`OPC_RU_LDu, 24'h000200, '0, 4'd2, 1'b1);
    tick;
    n_tests++;
    if (m_req !== 1'b1 || m_addr !== 24'h000200 || o_gp_we !== 1'b0) begin
      n_fail++; $display("FAIL b2b_req2 got req=%b addr=%h gpwe=%b want 1/000200/0", m_req, m_addr, o_gp_we); end
    ack = 1'b1; rdata = 24'h000222;
    tick;
    ack = 1'b0;
    n_tests++;
    if (m_req !== 1'b0 || o_result !== 24'h000222 || o_gp !== 4'd2 || o_gp_we !== 1'b1) begin
      n_fail++; $display("FAIL b2b_wb2 got req=%b res=%h gp=%0d want 0/000222/2", m_req, o_result, o_gp); end
  endtask

  task automatic test_reset_mid;
    set_op(`OPC_RU_LDu, 24'h000055, '0, 4'd6, 1'b1);
    tick;
    tick;
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (m_req !== 1'b0 || o_result !== '0 || o_gp !== '0 || o_pc !== '0 || m_addr !== '0) begin
      n_fail++; $display("FAIL rmid_async got req=%b res=%h gp=%0d addr=%h want all 0", m_req, o_result, o_gp, m_addr); end
    @(negedge clk);
    rst = 1'b0;
    tick;
    n_tests++;
    if (m_req !== 1'b1 || m_addr !== 24'h000055 || o_gp_we !== 1'b0) begin
      n_fail++; $display("FAIL rmid_reissue got req=%b addr=%h we=%b want 1/000055/0", m_req, m_addr, o_gp_we); end
    ack = 1'b1; rdata = 24'h000abc;
    tick;
    ack = 1'b0;
    n_tests++;
    if (o_result !== 24'h000abc || o_gp !== 4'd6 || m_req !== 1'b0) begin
      n_fail++; $display("FAIL rmid_wb got res=%h gp=%0d req=%b want 000abc/6/0", o_result, o_gp, m_req); end
    set_op(OPC_ADD, '0, '0, '0, 1'b0);
  endtask

`ifdef STG_MA_TIMEOUT_EN
  task automatic test_timeout;
    set_op(`OPC_RU_LDu, 24'h000066, 24'h000333, 4'd7, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick;
      n_tests++;
      if (m_req !== 1'b1 || m_fault !== 1'b0 || stall !== (i != 3)) begin
        n_fail++; $display("FAIL to_wait%0d got req=%b fault=%b stall=%b want 1/0/%b", i, m_req, m_fault, stall, i != 3); end
    end
    tick;
    n_tests++;
    if (m_fault !== 1'b1 || m_req !== 1'b0 || o_gp_we !== 1'b0 || o_result !== '0 || o_gp !== 4'd7) begin
      n_fail++; $display("FAIL to_abort got fault=%b req=%b we=%b res=%h gp=%0d want 1/0/0/0/7", m_fault, m_req, o_gp_we, o_result, o_gp); end
    set_op(OPC_ADD, '0, '0, '0, 1'b0);
    tick;
    n_tests++;
    if (m_fault !== 1'b0) begin n_fail++; $display("FAIL to_pulse got=%b want=0", m_fault); end
  endtask
`else
  task automatic test_no_timeout;
    set_op(`OPC_RU_LDu, 24'h000066, '0, 4'd7, 1'b1);
    repeat (20) tick;
    n_tests++;
    if (m_req !== 1'b1 || m_fault !== 1'b0 || stall !== 1'b1 || o_gp_we !== 1'b0) begin
      n_fail++; $display("FAIL nto_wait got req=%b fault=%b stall=%b want 1/0/1", m_req, m_fault, stall); end
    ack = 1'b1; rdata = 24'h000777;
    tick;
    ack = 1'b0;
    n_tests++;
    if (o_result !== 24'h000777 || o_gp_we !== 1'b1 || m_req !== 1'b0) begin
      n_fail++; $display("FAIL nto_wb got res=%h we=%b req=%b want 000777/1/0", o_result, o_gp_we, m_req); end
    set_op(OPC_ADD, '0, '0, '0, 1'b0);
  endtask
`endif

  initial begin
    test_reset;
    test_alu;
    test_load;
    test_store;
    test_back_to_back;
    test_reset_mid;
`ifdef STG_MA_TIMEOUT_EN
    test_timeout;
`else
    test_no_timeout;
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
